// File: rtl/scu_irq_ctrl.sv
// SCU interrupt controller: pending/mask registers, fixed-index priority, IRL/vector drive to SH-2.
// Define SCU_IRQ_CPU_IMASK_EN to add the CPU_IMASK level filter input.
module scu_irq_ctrl #(
    parameter int unsigned          NUM_SRC   = 16,
    parameter logic [NUM_SRC*4-1:0] SRC_LVL   = {NUM_SRC{4'hF}},
    parameter logic [7:0]           VEC_BASE  = 8'h40,
    parameter int unsigned          EXT_FIRST = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic [NUM_SRC-1:0] SRC_REQ,
    input  logic [1:0]         REG_SEL,
    input  logic               REG_WR,
    input  logic [31:0]        REG_DI,
    output logic [31:0]        REG_DO,
    output logic [3:0]         IRL,
    output logic [7:0]         VEC,
`ifdef SCU_IRQ_CPU_IMASK_EN
    input  logic [3:0]         CPU_IMASK,
`endif
    input  logic               IACK
);
    typedef enum logic [1:0] {StIdle, StAssert, StAcked} state_e;

    state_e             state_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pend_q;
    logic               aiack_q;
    logic               ext_busy_q;
    logic [4:0]         win_idx_q;

    logic [NUM_SRC-1:0] lvl_ok;
    logic [NUM_SRC-1:0] elig;
    logic               win_vld;
    logic [4:0]         win_idx;
    logic [3:0]         win_lvl;
    logic               cur_elig;
    logic               cur_ext;
    logic               wr_mask;
    logic               wr_stat;
    logic               wr_aiack;
    logic               ack;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] stat_clr;
    logic [NUM_SRC-1:0] pend_d;
    logic               unused_di;

    assign unused_di = ^REG_DI;

    always_comb begin
        lvl_ok = '0;
        elig   = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
`ifdef SCU_IRQ_CPU_IMASK_EN
            lvl_ok[i] = SRC_LVL[i*4 +: 4] > CPU_IMASK;
`else
            lvl_ok[i] = SRC_LVL[i*4 +: 4] != 4'd0;
`endif
            elig[i] = pend_q[i] && !mask_q[i] && lvl_ok[i]
                      && !((i >= int'(EXT_FIRST)) && ext_busy_q);
        end
    end

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        win_lvl  = '0;
        cur_elig = 1'b0;
        cur_ext  = 1'b0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_vld = 1'b1;
                win_idx = 5'(i);
                win_lvl = SRC_LVL[i*4 +: 4];
            end
        end
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (win_idx_q == 5'(i)) begin
                cur_elig = elig[i];
                cur_ext  = (i >= int'(EXT_FIRST));
            end
        end
    end

    always_comb begin
        wr_mask  = CE && REG_WR && (REG_SEL == 2'd0);
        wr_stat  = CE && REG_WR && (REG_SEL == 2'd1);
        wr_aiack = CE && REG_WR && (REG_SEL == 2'd2);
        ack      = CE && IACK && (state_q == StAssert);
        ack_clr  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            ack_clr[i] = ack && (win_idx_q == 5'(i));
        end
        stat_clr = wr_stat ? ~REG_DI[NUM_SRC-1:0] : '0;
        // A new request on the same cycle as a clear keeps the bit set.
        pend_d   = (pend_q & ~stat_clr & ~ack_clr) | SRC_REQ;
    end

    always_comb begin
        REG_DO = '0;
        case (REG_SEL)
            2'd1:    REG_DO[NUM_SRC-1:0] = pend_q;
            2'd2:    REG_DO[0] = aiack_q;
            default: REG_DO = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            mask_q     <= '1;
            pend_q     <= '0;
            aiack_q    <= 1'b0;
            ext_busy_q <= 1'b0;
            win_idx_q  <= '0;
            IRL        <= '0;
            VEC        <= '0;
        end else if (CE) begin
            pend_q <= pend_d;
            if (wr_mask) begin
                mask_q <= REG_DI[NUM_SRC-1:0];
            end
            if (wr_aiack) begin
                aiack_q <= REG_DI[0];
            end
            if (ack && cur_ext) begin
                ext_busy_q <= 1'b1;
            end else if (wr_aiack && REG_DI[0]) begin
                ext_busy_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (win_vld) begin
                        win_idx_q <= win_idx;
                        IRL       <= win_lvl;
                        VEC       <= VEC_BASE + {3'b000, win_idx};
                        state_q   <= StAssert;
                    end
                end
                StAssert: begin
                    if (IACK) begin
                        IRL     <= '0;
                        state_q <= StAcked;
                    end else if (!cur_elig) begin
                        IRL     <= '0;
                        VEC     <= '0;
                        state_q <= StIdle;
                    end else if (win_vld && (win_idx < win_idx_q)) begin
                        win_idx_q <= win_idx;
                        IRL       <= win_lvl;
                        VEC       <= VEC_BASE + {3'b000, win_idx};
                    end
                end
                StAcked: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_scu_irq_ctrl.sv
// Randomised bench for scu_irq_ctrl against a behavioural interrupt model, plus directed scenarios.
module tb_scu_irq_ctrl;
    localparam int          NS  = 16;
    localparam int          EXT = 12;
    localparam logic [63:0] LVL = 64'hF123_4568_90BC_DE7F;
    localparam logic [7:0]  VB  = 8'h40;

    logic        clk = 1'b0;
    logic        rst, ce, reg_wr, iack;
    logic [15:0] src_req;
    logic [1:0]  reg_sel;
    logic [31:0] reg_di, reg_do;
    logic [3:0]  irl;
    logic [7:0]  vec;
`ifdef SCU_IRQ_CPU_IMASK_EN
    logic [3:0]  cpu_imask = 4'd0;
`endif

    always #5 clk = ~clk;

    scu_irq_ctrl #(
        .NUM_SRC   (NS),
        .SRC_LVL   (LVL),
        .VEC_BASE  (VB),
        .EXT_FIRST (EXT)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .CE        (ce),
        .SRC_REQ   (src_req),
        .REG_SEL   (reg_sel),
        .REG_WR    (reg_wr),
        .REG_DI    (reg_di),
        .REG_DO    (reg_do),
        .IRL       (irl),
        .VEC       (vec),
`ifdef SCU_IRQ_CPU_IMASK_EN
        .CPU_IMASK (cpu_imask),
`endif
        .IACK      (iack)
    );

    // Source levels, written out independently of the packed parameter.
    int lvl_tab [NS] = '{15, 7, 14, 13, 12, 11, 0, 9, 8, 6, 5, 4, 3, 2, 1, 15};

    int n_checks = 0;
    int n_errors = 0;

    bit [15:0] m_pend, m_mask;
    bit        m_aiack, m_busy, m_acked;
    int        m_cur;
    logic [3:0] m_irl;
    logic [7:0] m_vec;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_elig(int i);
        bit ok = m_pend[i] && !m_mask[i] && (lvl_tab[i] != 0) && !(i >= EXT && m_busy);
`ifdef SCU_IRQ_CPU_IMASK_EN
        ok = ok && (lvl_tab[i] > int'(cpu_imask));
`endif
        return ok;
    endfunction

    function automatic logic [31:0] m_do();
        case (reg_sel)
            2'd1:    return {16'h0, m_pend};
            2'd2:    return {31'h0, m_aiack};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '1; m_aiack = 0; m_busy = 0; m_acked = 0;
        m_cur = -1; m_irl = 0; m_vec = 0;
    endtask

    // One clock edge of the interrupt controller, from the rules in terms of sources.
    task automatic model_step();
        int win = -1;
        int clr = -1;
        bit busy_set = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!ce) return;
        for (int i = NS - 1; i >= 0; i--) if (m_elig(i)) win = i;
        if (m_acked) begin
            m_acked = 0;
        end else if (m_cur < 0) begin
            if (win >= 0) begin
                m_cur = win; m_irl = 4'(lvl_tab[win]); m_vec = VB + 8'(win);
            end
        end else if (iack) begin
            clr = m_cur; busy_set = (m_cur >= EXT);
            m_irl = 0; m_acked = 1; m_cur = -1;
        end else if (!m_elig(m_cur)) begin
            m_irl = 0; m_vec = 0; m_cur = -1;
        end else if (win >= 0 && win < m_cur) begin
            m_cur = win; m_irl = 4'(lvl_tab[win]); m_vec = VB + 8'(win);
        end
        for (int i = 0; i < NS; i++) begin
            if (src_req[i]) m_pend[i] = 1;
            else if ((reg_wr && reg_sel == 2'd1 && !reg_di[i]) || i == clr) m_pend[i] = 0;
        end
        if (busy_set) m_busy = 1;
        else if (reg_wr && reg_sel == 2'd2 && reg_di[0]) m_busy = 0;
        if (reg_wr && reg_sel == 2'd0) m_mask = reg_di[15:0];
        if (reg_wr && reg_sel == 2'd2) m_aiack = reg_di[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("irl", {28'h0, irl}, {28'h0, m_irl});
        if (m_irl != 4'd0) check_eq("vec", {24'h0, vec}, {24'h0, m_vec});
        check_eq("reg_do", reg_do, m_do());
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [31:0] data);
        reg_wr = 1; reg_sel = sel; reg_di = data;
        tick();
        reg_wr = 0; reg_sel = 2'd1; reg_di = 0;
        #1;
    endtask

    task automatic pulse(input logic [15:0] req);
        src_req = req;
        tick();
        src_req = 0;
    endtask

    task automatic do_ack();
        iack = 1;
        tick();
        iack = 0;
    endtask

    initial begin
        model_reset();
        rst = 1; ce = 1; reg_wr = 0; iack = 0; src_req = 0; reg_sel = 2'd1; reg_di = 0;
        tick(); tick();
        rst = 0;
        check_eq("rst_vec", {24'h0, vec}, 32'h0);
        check_eq("rst_stat", reg_do, 32'h0);

        // Reset leaves everything masked.
        pulse(16'h0001); tick(); tick();
        check_eq("rst_masked_irl", {28'h0, irl}, 32'h0);
        wr_reg(2'd1, 32'hFFFF_FFFE);

        // Single source, two-cycle latency, ack drop.
        wr_reg(2'd0, 32'h0000_FFFE);
        pulse(16'h0001); tick();
        check_eq("t1_irl", {28'h0, irl}, 32'hF);
        check_eq("t1_vec", {24'h0, vec}, 32'h40);
        do_ack();
        check_eq("t1_ack_irl", {28'h0, irl}, 32'h0);
        check_eq("t1_stat", reg_do, 32'h0);
        tick();

        // Two sources at once: lower index first.
        wr_reg(2'd0, 32'h0);
        pulse(16'h0024); tick();
        check_eq("t2_vec_first", {24'h0, vec}, 32'h42);
        do_ack();
        check_eq("t2_stat_mid", reg_do, 32'h20);
        tick(); tick();
        check_eq("t2_vec_second", {24'h0, vec}, 32'h45);
        do_ack();
        check_eq("t2_stat_end", reg_do, 32'h0);
        tick();

        // Withdraw on masking before ack.
        pulse(16'h0080); tick();
        check_eq("t3_irl", {28'h0, irl}, 32'h9);
        wr_reg(2'd0, 32'h0080);
        tick();
        check_eq("t3_withdraw", {28'h0, irl}, 32'h0);
        check_eq("t3_stat", reg_do, 32'h80);
        wr_reg(2'd1, 32'hFFFF_FF7F);
        wr_reg(2'd0, 32'h0);

        // External gating by ext_busy until aiack.
        pulse(16'h1000); tick();
        check_eq("t4_vec12", {24'h0, vec}, 32'h4C);
        do_ack(); tick();
        pulse(16'h2000); tick(); tick();
        check_eq("t4_gated", {28'h0, irl}, 32'h0);
        wr_reg(2'd2, 32'h1);
        tick();
        check_eq("t4_irl13", {28'h0, irl}, 32'h2);
        check_eq("t4_vec13", {24'h0, vec}, 32'h4D);
        reg_sel = 2'd2; #1;
        check_eq("t4_aiack", reg_do, 32'h1);
        reg_sel = 2'd1;
        do_ack(); tick();
        wr_reg(2'd2, 32'h1);

        // Status clear and new request on the same bit: set wins.
        src_req = 16'h0008; reg_wr = 1; reg_sel = 2'd1; reg_di = 32'hFFFF_FFF7;
        tick();
        src_req = 0; reg_wr = 0; reg_di = 0; #1;
        check_eq("t5_set_wins", {31'h0, reg_do[3]}, 32'h1);
        tick();
        do_ack(); tick();

`ifdef SCU_IRQ_CPU_IMASK_EN
        cpu_imask = 4'd7;
        pulse(16'h0002); tick(); tick();
        check_eq("t6_imask_block", {28'h0, irl}, 32'h0);
        cpu_imask = 4'd6;
        tick();
        check_eq("t6_imask_pass", {28'h0, irl}, 32'h7);
        do_ack(); tick();
        cpu_imask = 4'd0;
`endif

        for (int n = 0; n < 4000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            ce      = ($urandom_range(0, 9) != 0);
            src_req = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
            iack    = ($urandom_range(0, 3) == 0);
            reg_wr  = ($urandom_range(0, 7) == 0);
            reg_sel = 2'($urandom);
            case (reg_sel)
                2'd0:    reg_di = $urandom & $urandom & $urandom;
                2'd1:    reg_di = ($urandom_range(0, 1) == 0) ? ~(32'd1 << $urandom_range(0, 15))
                                                              : ($urandom | $urandom);
                default: reg_di = $urandom;
            endcase
`ifdef SCU_IRQ_CPU_IMASK_EN
            if ($urandom_range(0, 15) == 0) cpu_imask = 4'($urandom);
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
